// File: rtl/sprite_pkg.sv
// Shared types for the sprite scheduler: descriptor layout and scheduler states.
package sprite_pkg;

  localparam int unsigned CANVAS_WIDTH_DEF  = 360;
  localparam int unsigned CANVAS_HEIGHT_DEF = 720;
  localparam int unsigned NUM_FRAMES_DEF    = 18;

  localparam int unsigned X_W    = $clog2(CANVAS_WIDTH_DEF);
  localparam int unsigned Y_W    = $clog2(CANVAS_HEIGHT_DEF);
  localparam int unsigned F_W    = $clog2(NUM_FRAMES_DEF);
  localparam int unsigned DESC_W = X_W + Y_W + F_W;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [F_W-1:0] frame;
  } sprite_desc_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

endpackage

// File: rtl/sprite_bank_ram.sv
// Simple dual-port descriptor RAM, address {bank, index}, registered read (1-cycle latency).
module sprite_bank_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Double-buffered sprite list: fills one bank while draining the other to the renderer.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned CANVAS_WIDTH  = 360,
  parameter int unsigned CANVAS_HEIGHT = 720,
  parameter int unsigned NUM_FRAMES    = 18,
  parameter int unsigned MAX_SPRITES   = 64
) (
  input  logic           clk_pixel,
  input  logic           rst_n_in,
  input  logic           new_frame,
  input  logic           in_valid,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  input  logic [F_W-1:0] in_frame,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic [F_W-1:0] out_frame,
  output logic           frame_done,
  output logic           late,
  output logic [7:0]     drop_count
);

  localparam int unsigned IDX_W = $clog2(MAX_SPRITES);
  localparam int unsigned CNT_W = $clog2(MAX_SPRITES + 1);
  localparam int unsigned AW    = IDX_W + 1;

  localparam logic [X_W:0]       X_LIM   = CANVAS_WIDTH[X_W:0];
  localparam logic [Y_W:0]       Y_LIM   = CANVAS_HEIGHT[Y_W:0];
  localparam logic [F_W:0]       F_LIM   = NUM_FRAMES[F_W:0];
  localparam logic [CNT_W-1:0]   CNT_MAX = MAX_SPRITES[CNT_W-1:0];

  sched_state_t     state_q, state_d;
  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] iss_idx;
  logic [CNT_W-1:0] dl_cnt;

  sprite_desc_t     in_desc;
  sprite_desc_t     ram_q;
  sprite_desc_t     out_q;
  sprite_desc_t     skid_q;
  logic             pend_q;
  logic             skid_valid;

  logic             in_ok;
  logic             wr_full;
  logic             wr_acc;
  logic             drop;
  logic             wr_tgt;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;

  logic             pop;
  logic             last_pop;
  logic             swap_has_data;
  logic [1:0]       occ;
  logic             rd_issue;
  logic             frame_done_d;
  logic             late_d;

  assign rd_bank = ~wr_bank;

  // ---------------------------------------------------------------- write path
  assign in_desc = '{x: in_x, y: in_y, frame: in_frame};
  assign in_ok   = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM) &&
                   ({1'b0, in_frame} < F_LIM);
  // A coinciding new_frame clears the target bank first, so it can never be full.
  assign wr_full = !new_frame && (cnt_q[wr_bank] >= CNT_MAX);
  assign wr_acc  = in_valid && in_ok && !wr_full;
  assign drop    = in_valid && !wr_acc;
  assign wr_tgt  = new_frame ? ~wr_bank : wr_bank;
  assign ram_waddr = new_frame ? {wr_tgt, {IDX_W{1'b0}}}
                               : {wr_tgt, cnt_q[wr_bank][IDX_W-1:0]};

  always_ff @(posedge clk_pixel or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_bank    <= 1'b0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      rd_count   <= '0;
      drop_count <= '0;
    end else begin
      if (new_frame) begin
        wr_bank         <= ~wr_bank;
        rd_count        <= cnt_q[wr_bank];
        cnt_q[~wr_bank] <= CNT_W'(wr_acc);
      end else if (wr_acc) begin
        cnt_q[wr_bank] <= cnt_q[wr_bank] + 1'b1;
      end
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  sprite_bank_ram #(
    .DEPTH (2 * MAX_SPRITES),
    .WIDTH (DESC_W)
  ) u_ram (
    .clk   (clk_pixel),
    .we    (wr_acc),
    .waddr (ram_waddr),
    .wdata (in_desc),
    .re    (rd_issue),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // ---------------------------------------------------------------- FSM
  assign swap_has_data = (cnt_q[wr_bank] != '0);
  assign pop           = out_valid && out_ready;
  assign last_pop      = (state_q == DRAIN) && pop && (dl_cnt == rd_count - 1'b1);
  // Entries held after this cycle's pop plus the read in flight; reads are
  // issued only while the output register and skid can absorb the result.
  assign occ = {1'b0, out_valid && !pop} + {1'b0, skid_valid} + {1'b0, pend_q};

  always_ff @(posedge clk_pixel or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_frame) begin
      state_d = swap_has_data ? DRAIN : IDLE;
    end else if (last_pop) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    rd_issue     = 1'b0;
    ram_raddr    = {rd_bank, iss_idx[IDX_W-1:0]};
    frame_done_d = 1'b0;
    late_d       = 1'b0;
    if (new_frame) begin
      // Prefetch entry 0 of the bank being handed over this very cycle.
      ram_raddr    = {wr_bank, {IDX_W{1'b0}}};
      rd_issue     = swap_has_data;
      late_d       = (state_q == DRAIN) && !last_pop;
      frame_done_d = last_pop || !swap_has_data;
    end else begin
      rd_issue     = (state_q == DRAIN) && (iss_idx < rd_count) && (occ < 2'd2);
      frame_done_d = last_pop;
    end
  end

  // ---------------------------------------------------------------- output stage
  always_ff @(posedge clk_pixel or negedge rst_n_in) begin
    if (!rst_n_in) begin
      iss_idx    <= '0;
      dl_cnt     <= '0;
      pend_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      frame_done <= 1'b0;
      late       <= 1'b0;
    end else begin
      frame_done <= frame_done_d;
      late       <= late_d;
      pend_q     <= rd_issue;
      if (new_frame) begin
        iss_idx    <= CNT_W'(rd_issue);
        dl_cnt     <= '0;
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (rd_issue) begin
          iss_idx <= iss_idx + 1'b1;
        end
        if (pop) begin
          dl_cnt <= dl_cnt + 1'b1;
        end
        if (pop || !out_valid) begin
          if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= pend_q;
            if (pend_q) begin
              skid_q <= ram_q;
            end
          end else begin
            out_valid <= pend_q;
            if (pend_q) begin
              out_q <= ram_q;
            end
          end
        end else if (pend_q) begin
          skid_valid <= 1'b1;
          skid_q     <= ram_q;
        end
      end
    end
  end

  assign out_x     = out_q.x;
  assign out_y     = out_q.y;
  assign out_frame = out_q.frame;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: ordering, filtering, bank limit, hold, abort and reset.
module tb_sprite_scheduler;
  import sprite_pkg::*;

  logic           clk_pixel = 1'b0;
  logic           rst_n_in;
  logic           new_frame;
  logic           in_valid;
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;
  logic [F_W-1:0] in_frame;
  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic [F_W-1:0] out_frame;
  logic           frame_done;
  logic           late;
  logic [7:0]     drop_count;

  int tests = 0;
  int fails = 0;

  always #5 clk_pixel = ~clk_pixel;

  sprite_scheduler #(
    .CANVAS_WIDTH  (360),
    .CANVAS_HEIGHT (720),
    .NUM_FRAMES    (18),
    .MAX_SPRITES   (64)
  ) dut (
    .clk_pixel  (clk_pixel),
    .rst_n_in   (rst_n_in),
    .new_frame  (new_frame),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_frame   (in_frame),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_frame  (out_frame),
    .frame_done (frame_done),
    .late       (late),
    .drop_count (drop_count)
  );

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int x, input int y, input int f);
    in_valid = 1'b1;
    in_x     = X_W'(x);
    in_y     = Y_W'(y);
    in_frame = F_W'(f);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] obs_d();
    return 64'({out_valid, out_x, out_y, out_frame});
  endfunction

  function automatic logic [63:0] exp_d(input int x, input int y, input int f);
    return 64'({1'b1, X_W'(x), Y_W'(y), F_W'(f)});
  endfunction

  initial begin
    int hs;
    int cyc;

    rst_n_in  = 1'b0;
    new_frame = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_frame  = '0;
    repeat (2) tick();
    chk("rst_out", obs_d(), 64'd0);
    chk("rst_flags", 64'({frame_done, late, drop_count}), 64'd0);
    rst_n_in = 1'b1;
    tick();

    // three sprites, drained back to back
    put(10, 20, 1);
    put(359, 719, 17);
    put(0, 0, 0);
    out_ready = 1'b1;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    chk("t1_T1_idle", 64'({out_valid, frame_done}), 64'd0);
    tick();
    chk("t1_e0", obs_d(), exp_d(10, 20, 1));
    tick();
    chk("t1_e1", obs_d(), exp_d(359, 719, 17));
    tick();
    chk("t1_e2", obs_d(), exp_d(0, 0, 0));
    tick();
    chk("t1_done", 64'({out_valid, frame_done}), 64'b01);
    tick();
    chk("t1_done_pulse", 64'(frame_done), 64'd0);

    // out-of-range fields, one at a time
    put(360, 0, 0);
    put(0, 720, 0);
    put(0, 0, 18);
    chk("t2_drops", 64'(drop_count), 64'd3);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    chk("t2_empty_done", 64'({out_valid, frame_done, late}), 64'b010);
    tick();
    chk("t2_after", 64'({out_valid, frame_done}), 64'd0);

    // 70 writes into a 64-entry bank
    for (int i = 0; i < 70; i++) put(i, 2 * i, i % 18);
    chk("t3_drops", 64'(drop_count), 64'd9);
    out_ready = 1'b1;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("t3_e%0d", i), obs_d(), exp_d(i, 2 * i, i % 18));
      tick();
    end
    chk("t3_done", 64'({out_valid, frame_done}), 64'b01);

    // backpressure hold then release
    for (int i = 0; i < 5; i++) put(100 + i, 200 + i, i);
    out_ready = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_hold%0d", k), obs_d(), exp_d(100, 200, 0));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_e%0d", i), obs_d(), exp_d(100 + i, 200 + i, i));
      tick();
    end
    chk("t4_done", 64'({out_valid, frame_done}), 64'b01);

    // abort a toggling drain after 20 handshakes
    for (int i = 0; i < 64; i++) put(i, i + 300, i % 18);
    out_ready = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    hs  = 0;
    cyc = 0;
    while (hs < 20 && cyc < 400) begin
      out_ready = (cyc % 2) == 1;
      if (cyc == 0) begin
        in_valid = 1'b1; in_x = 9'd7;  in_y = 10'd8;  in_frame = 5'd9;
      end else if (cyc == 1) begin
        in_valid = 1'b1; in_x = 9'd11; in_y = 10'd12; in_frame = 5'd13;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("t5_e%0d", hs), obs_d(), exp_d(hs, hs + 300, hs % 18));
        hs++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t5_handshakes", 64'(hs), 64'd20);
    out_ready = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    chk("t5_abort", 64'({late, out_valid, frame_done}), 64'b100);
    tick();
    chk("t5_late_pulse", 64'(late), 64'd0);
    chk("t5_n0", obs_d(), exp_d(7, 8, 9));
    out_ready = 1'b1;
    tick();
    chk("t5_n1", obs_d(), exp_d(11, 12, 13));
    tick();
    chk("t5_done", 64'({out_valid, frame_done}), 64'b01);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) put(50 + i, 60 + i, i);
    out_ready = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    chk("t6_pre", obs_d(), exp_d(50, 60, 0));
    #2 rst_n_in = 1'b0;
    #1;
    chk("t6_rst_out", obs_d(), 64'd0);
    chk("t6_rst_flags", 64'({frame_done, late, drop_count}), 64'd0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    chk("t6_empty_done", 64'({out_valid, frame_done}), 64'b01);
    out_ready = 1'b1;
    tick();
    chk("t6_nothing", 64'({out_valid, frame_done}), 64'd0);
    tick();
    chk("t6_nothing2", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
